// File: rtl/pc_fetch.sv
// PC register, instruction-bus fetch engine and IF/ID pipeline register.
// One outstanding request; a fetched word can be parked while IF stalls.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic [31:0] exception_handle_addr_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        stall_req_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic        id_adel_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_q;

  logic        mis;
  logic        dlv;
  logic        take;
  logic        id_hold;
  logic [31:0] word;
  logic [31:0] pc_next;

  assign mis     = |pc[1:0];
  assign dlv     = (state == S_WAIT && ibus_ack_i)
                || (state == S_HOLD)
                || (state == S_IDLE && mis);
  assign take    = dlv && !stall_i[1];
  assign id_hold = stall_i[1] && stall_i[2];
  assign pc_next = branch_flag_i ? branch_target_i
                                 : pc + 32'd4;

  // Misaligned PC never reaches the bus; it delivers a NOP word.
  always_comb begin
    word = ibus_rdata_i;
    unique case (1'b1)
      state == S_HOLD: word = hold_q;
      state == S_IDLE: word = '0;
      default:         word = ibus_rdata_i;
    endcase
  end

  assign ibus_req_o  = (state == S_WAIT) || (state == S_DROP);
  assign ibus_addr_o = pc;
  assign stall_req_o = (state == S_WAIT) && !ibus_ack_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      hold_q     <= '0;
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
      id_adel_o  <= 1'b0;
    end else if (flush_i) begin
      pc         <= exception_handle_addr_i;
      hold_q     <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
      id_adel_o  <= 1'b0;
      // An unacknowledged request must still complete on the bus.
      case (state)
        S_WAIT:  state <= ibus_ack_i ? S_IDLE : S_DROP;
        S_DROP:  state <= S_DROP;
        default: state <= S_IDLE;
      endcase
    end else begin
      if (take) begin
        id_pc_o    <= pc;
        id_inst_o  <= word;
        id_valid_o <= 1'b1;
        id_adel_o  <= (state == S_IDLE);
        if (!stall_i[0])
          pc <= pc_next;
      end else if (!id_hold) begin
        id_inst_o  <= '0;
        id_valid_o <= 1'b0;
        id_adel_o  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (!mis)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (ibus_ack_i) begin
            if (stall_i[1]) begin
              hold_q <= ibus_rdata_i;
              state  <= S_HOLD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i[1])
            state <= S_IDLE;
        end
        S_DROP: begin
          if (ibus_ack_i)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
